seg_disp_seq_conv: RTL

- Sequential value-to-display converter for the multi-digit seven-segment bank.
- Accepts a binary value on a start pulse and converts it to mixed-radix digits with a bit-serial divider, one digit at a time.
- Encodes each digit to segments with per-mode decimal points, leading-zero blanking and overflow indication.
- Publishes all digits atomically on completion. Sits between the stopwatch/counter core and the HEX display pins.

---
 rtl/seg_disp_pkg.sv | 40 ++++
 rtl/seg_disp_seq_conv_if.sv | 26 ++
 rtl/seg_glyph_rom.sv | 20 ++
 rtl/seg_disp_seq_conv.sv | 137 +++++++++++++
 4 files changed

// File: rtl/seg_disp_pkg.sv
// Shared definitions for the sequential seven-segment display converter.
// Holds the mode encoding, per-digit radix table for time mode, decimal-point
// mask, special segment patterns, glyph table and FSM state constants.
package seg_disp_pkg;

  typedef enum logic {
    MODE_DEC  = 1'b0,
    MODE_TIME = 1'b1
  } mode_e;

  // FSM states
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] NEXT = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  // Time-mode radices, LSD in the low nibble: 10,10,10,6,10,6 then 10 above.
  localparam logic [31:0] TIME_RADIX = {4'd10, 4'd10, 4'd6, 4'd10, 4'd6, 4'd10, 4'd10, 4'd10};

  // dp lit on digits 4 and 2 in time mode (separates hh.mm.ss-style groups).
  localparam logic [7:0] TIME_DP_MASK = 8'b0001_0100;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  // Active-low g..a patterns for digits 0..9, digit 0 in the low 7 bits.
  localparam logic [69:0] GLYPH_TABLE = {7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
                                         7'h19, 7'h30, 7'h24, 7'h79, 7'h40};

  function automatic logic [3:0] radix_of(input mode_e m, input logic [2:0] d);
    if (m == MODE_TIME) return TIME_RADIX[4*d +: 4];
    return 4'd10;
  endfunction

  function automatic logic [6:0] glyph_of(input logic [3:0] d);
    if (d > 4'd9) return 7'h7F;
    return GLYPH_TABLE[7*d +: 7];
  endfunction

endpackage

// File: rtl/seg_disp_seq_conv_if.sv
// Request/result bundle between the counter core and the display converter.
//   start/value/mode/blank_en : request side, driven by the master
//   busy/done/overflow/seg    : status and display result, driven by the slave
interface seg_disp_seq_conv_if #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned VALUE_W    = 20
);
  logic                      start;
  logic [VALUE_W-1:0]        value;
  logic                      mode;
  logic                      blank_en;
  logic                      busy;
  logic                      done;
  logic                      overflow;
  logic [NUM_DIGITS*8-1:0]   seg;

  modport master (
    output start, value, mode, blank_en,
    input  busy, done, overflow, seg
  );

  modport slave (
    input  start, value, mode, blank_en,
    output busy, done, overflow, seg
  );
endinterface

// File: rtl/seg_glyph_rom.sv
// Combinational digit-to-segment encoder for one display position.
//   digit : 4-bit digit code (0..9 meaningful)
//   dp    : light the decimal point
//   blank : force every segment and dp off
//   seg   : active-low pattern, bit7 = dp, bits6:0 = g..a
module seg_glyph_rom
  import seg_disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank && digit <= 4'd9) seg = {~dp, glyph_of(digit)};
  end

endmodule

// File: rtl/seg_disp_seq_conv.sv
// Sequential value-to-display converter. A start pulse latches a binary value;
// a bit-serial restoring divider peels off one mixed-radix digit per pass, and
// all digits are encoded and published together when the last one is ready.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of seg_disp_seq_conv_if (start/value/mode/blank_en
//                in; busy/done/overflow/seg out)
module seg_disp_seq_conv
  import seg_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned VALUE_W    = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seg_disp_seq_conv_if.slave   bus
);

  localparam int unsigned CW = $clog2(VALUE_W);
  localparam logic [CW-1:0] LAST_BIT = CW'(VALUE_W - 1);
  localparam logic [2:0]    LAST_D   = 3'(NUM_DIGITS - 1);

  logic [1:0]              state;
  logic [VALUE_W-1:0]      r;
  logic [3:0]              rem;
  logic [CW-1:0]           bit_cnt;
  logic [2:0]              d;
  mode_e                   mode_q;
  logic                    blank_q;
  logic                    ready_q;
  logic                    done_q;
  logic                    ovf_q;
  logic [NUM_DIGITS*8-1:0] seg_q;
  logic [3:0]              digits [NUM_DIGITS];

  logic [3:0]              radix;
  logic [4:0]              trial;
  logic [4:0]              diff;
  logic                    qbit;
  logic [3:0]              rem_nxt;
  logic [NUM_DIGITS-1:0]   blank_vec;
  logic [NUM_DIGITS*8-1:0] seg_enc;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    radix   = radix_of(mode_q, d);
    trial   = {rem, r[VALUE_W-1]};
    diff    = trial - {1'b0, radix};
    qbit    = trial >= {1'b0, radix};
    rem_nxt = qbit ? diff[3:0] : trial[3:0];
  end

  // Blank zeros above the most significant nonzero digit; digit 0 always shows.
  always_comb begin
    logic lead;
    lead = (mode_q == MODE_DEC) && blank_q;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      blank_vec[i] = lead && (digits[i] == 4'd0) && (i != 0);
      if (digits[i] != 4'd0) lead = 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_glyph
    seg_glyph_rom u_glyph (
      .digit (digits[i]),
      .dp    ((mode_q == MODE_TIME) && TIME_DP_MASK[i]),
      .blank (blank_vec[i]),
      .seg   (seg_enc[8*i +: 8])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      r       <= '0;
      rem     <= '0;
      bit_cnt <= '0;
      d       <= '0;
      mode_q  <= MODE_DEC;
      blank_q <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      seg_q   <= {NUM_DIGITS{SEG_BLANK}};
      for (int i = 0; i < NUM_DIGITS; i++) digits[i] <= '0;
    end else begin
      // ready_q keeps a start coincident with reset release from being taken.
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && ready_q && !done_q) begin
            r       <= bus.value;
            mode_q  <= mode_e'(bus.mode);
            blank_q <= bus.blank_en;
            d       <= '0;
            bit_cnt <= '0;
            rem     <= '0;
            state   <= DIV;
          end
        end
        DIV: begin
          r       <= {r[VALUE_W-2:0], qbit};
          rem     <= rem_nxt;
          bit_cnt <= bit_cnt + CW'(1);
          if (bit_cnt == LAST_BIT) begin
            digits[d] <= rem_nxt;
            state     <= NEXT;
          end
        end
        NEXT: begin
          rem     <= '0;
          bit_cnt <= '0;
          if (d == LAST_D) begin
            state <= FIN;
          end else begin
            d     <= d + 3'd1;
            state <= DIV;
          end
        end
        FIN: begin
          // Anything left in r means the value did not fit in NUM_DIGITS digits.
          seg_q  <= (r != '0) ? {NUM_DIGITS{SEG_DASH}} : seg_enc;
          ovf_q  <= (r != '0);
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE) || done_q;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
  assign bus.seg      = seg_q;

endmodule
